alu8_seq: RTL and testbench

ALU8_SEQ -- requirements
Module: alu8_seq

---
 rtl/alu8_seq_pkg.sv | 21 ++
 rtl/alu8_seq_nib_alu.sv | 34 +++
 rtl/alu8_seq.sv | 127 ++++++++++++
 tb/tb_alu8_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_seq_pkg.sv
// Shared types and widths for the nibble-serial 8-bit ALU.
package alu8_seq_pkg;

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      RESP
   } state_e;

endpackage

// File: rtl/alu8_seq_nib_alu.sv
// Combinational 4-bit ALU slice; inverts b internally for SUB.
module nib_alu
   import alu8_seq_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic [1:0]       f,
   input  logic             cin,
   output logic [NIB_W-1:0] y,
   output logic             cout
);

   logic [NIB_W-1:0] b_eff;
   logic [NIB_W:0]   sum;

   always_comb begin
      b_eff = (op_e'(f) == SUB) ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{NIB_W{1'b0}}, cin};
      y     = sum[NIB_W-1:0];
      cout  = sum[NIB_W];
      case (op_e'(f))
         AND: begin
            y    = a & b;
            cout = 1'b0;
         end
         OR: begin
            y    = a | b;
            cout = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu8_seq.sv
// 8-bit ADD/SUB/AND/OR computed as two nibble passes with valid/ready handshakes.
// Optional sticky overflow flag enabled by ALU8_SEQ_STICKY_OVF_EN.
module alu8_seq
   import alu8_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [1:0]        req_f,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_y,
   output logic              rsp_zero,
   output logic              rsp_ovf,
   output logic              rsp_carry,
   output logic              rsp_neg
`ifdef ALU8_SEQ_STICKY_OVF_EN
   ,
   input  logic              clr_sticky,
   output logic              sticky_ovf
`endif
);

   state_e            state;
   logic [DATA_W-1:0] a_q, b_q;
   op_e               op_q;
   logic [NIB_W-1:0]  lo_y_q;
   logic              lo_c_q;

   logic [NIB_W-1:0]  nib_a, nib_b, nib_y;
   logic              nib_cin, nib_cout;
   logic              arith, b7_eff, ovf_calc;
   logic [DATA_W-1:0] full_y;

   // Nibble select follows the pass; high pass chains the low-pass carry.
   always_comb begin
      arith    = (op_q == ADD) || (op_q == SUB);
      nib_a    = (state == HI) ? a_q[DATA_W-1:NIB_W] : a_q[NIB_W-1:0];
      nib_b    = (state == HI) ? b_q[DATA_W-1:NIB_W] : b_q[NIB_W-1:0];
      nib_cin  = (state == HI) ? lo_c_q : (op_q == SUB);
      b7_eff   = (op_q == SUB) ? ~b_q[DATA_W-1] : b_q[DATA_W-1];
      ovf_calc = arith && (a_q[DATA_W-1] == b7_eff) && (nib_y[NIB_W-1] != a_q[DATA_W-1]);
      full_y   = {nib_y, lo_y_q};
   end

   nib_alu u_nib_alu (
      .a    (nib_a),
      .b    (nib_b),
      .f    (op_q),
      .cin  (nib_cin),
      .y    (nib_y),
      .cout (nib_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= ADD;
         lo_y_q    <= '0;
         lo_c_q    <= 1'b0;
         rsp_y     <= '0;
         rsp_zero  <= 1'b0;
         rsp_ovf   <= 1'b0;
         rsp_carry <= 1'b0;
         rsp_neg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  a_q       <= req_a;
                  b_q       <= req_b;
                  op_q      <= op_e'(req_f);
                  req_ready <= 1'b0;
                  state     <= LO;
               end
            end
            LO: begin
               lo_y_q <= nib_y;
               lo_c_q <= nib_cout;
               state  <= HI;
            end
            HI: begin
               rsp_y     <= full_y;
               rsp_zero  <= (full_y == '0);
               rsp_neg   <= nib_y[NIB_W-1];
               rsp_carry <= arith && nib_cout;
               rsp_ovf   <= ovf_calc;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU8_SEQ_STICKY_OVF_EN
   // Set has priority over clear when both land on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
      end else if ((state == HI) && ovf_calc) begin
         sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
         sticky_ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu8_seq.sv
// Scoreboard bench for alu8_seq; covers sticky overflow when ALU8_SEQ_STICKY_OVF_EN is set.
module tb_alu8_seq;
   import alu8_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_a = '0;
   logic [7:0] req_b = '0;
   logic [1:0] req_f = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_y;
   logic       rsp_zero, rsp_ovf, rsp_carry, rsp_neg;
`ifdef ALU8_SEQ_STICKY_OVF_EN
   logic       clr_sticky = 1'b0;
   logic       sticky_ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] y;
      logic       zero;
      logic       ovf;
      logic       carry;
      logic       neg;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu8_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_f      (req_f),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_y      (rsp_y),
      .rsp_zero   (rsp_zero),
      .rsp_ovf    (rsp_ovf),
      .rsp_carry  (rsp_carry),
      .rsp_neg    (rsp_neg)
`ifdef ALU8_SEQ_STICKY_OVF_EN
      ,
      .clr_sticky (clr_sticky),
      .sticky_ovf (sticky_ovf)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Plain 9-bit reference arithmetic, independent of the nibble split.
   function automatic exp_t model(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      exp_t       e;
      e = '0;
      s = '0;
      case (f)
         2'b00: begin
            s       = {1'b0, a} + {1'b0, b};
            e.carry = s[8];
            e.ovf   = (a[7] == b[7]) && (s[7] != a[7]);
         end
         2'b01: begin
            s       = {1'b0, a} + {1'b0, ~b} + 9'd1;
            e.carry = s[8];
            e.ovf   = (a[7] != b[7]) && (s[7] != a[7]);
         end
         2'b10: s = {1'b0, a & b};
         default: s = {1'b0, a | b};
      endcase
      e.y    = s[7:0];
      e.zero = (s[7:0] == 8'h00);
      e.neg  = s[7];
      return e;
   endfunction

   task automatic check_rsp(input string tag, input exp_t e);
      check_eq({tag, "_y"}, rsp_y, e.y);
      check_eq({tag, "_zero"}, rsp_zero, e.zero);
      check_eq({tag, "_ovf"}, rsp_ovf, e.ovf);
      check_eq({tag, "_carry"}, rsp_carry, e.carry);
      check_eq({tag, "_neg"}, rsp_neg, e.neg);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("req_ready_wait", req_ready, 1);
   endtask

   // Drives one op; req_valid stays high with scrambled data while busy.
   task automatic run_op(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b,
                         input int stall, input bit clr_in_hi);
      exp_t e;
      wait_ready();
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_f     = f;
      sb.push_back(model(f, a, b));
      @(posedge clk);
      #1;
      req_a = ~a;
      req_b = 8'($urandom);
      req_f = ~f;
      check_eq("lat_c1_valid", rsp_valid, 0);
      check_eq("busy_ready", req_ready, 0);
      @(posedge clk);
      #1;
      check_eq("lat_c2_valid", rsp_valid, 0);
`ifdef ALU8_SEQ_STICKY_OVF_EN
      if (clr_in_hi) clr_sticky = 1'b1;
`endif
      @(posedge clk);
      #1;
`ifdef ALU8_SEQ_STICKY_OVF_EN
      clr_sticky = 1'b0;
`endif
      check_eq("lat_c3_valid", rsp_valid, 1);
      e = '0;
      if (sb.size() > 0) e = sb.pop_front();
      else check_eq("sb_underflow", 1, 0);
      check_rsp("rsp", e);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         check_eq("stall_valid", rsp_valid, 1);
         check_eq("stall_ready", req_ready, 0);
         check_rsp("stall", e);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check_eq("post_hs_ready", req_ready, 1);
      check_eq("post_hs_valid", rsp_valid, 0);
      check_rsp("hold", e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rsp_y", rsp_y, 0);
      check_eq("rst_flags", {rsp_zero, rsp_ovf, rsp_carry, rsp_neg}, 0);
`ifdef ALU8_SEQ_STICKY_OVF_EN
      check_eq("rst_sticky", sticky_ovf, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_release_ready", req_ready, 1);

      run_op(2'(ADD), 8'h7F, 8'h01, 0, 1'b0);
      run_op(2'(ADD), 8'hFF, 8'h01, 0, 1'b0);
      run_op(2'(SUB), 8'h10, 8'h10, 0, 1'b0);
      run_op(2'(SUB), 8'h80, 8'h01, 0, 1'b0);
      run_op(2'(AND), 8'hF0, 8'h3C, 0, 1'b0);
      run_op(2'(OR),  8'hF0, 8'h0C, 5, 1'b0);
      for (int i = 0; i < 8; i++) begin
         run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0, 1'b0);
      end

      // Abandon an op in HI; prior result must be cleared at once.
      run_op(2'(ADD), 8'h12, 8'h34, 0, 1'b0);
      wait_ready();
      req_valid = 1'b1;
      req_a     = 8'h55;
      req_b     = 8'h22;
      req_f     = 2'(ADD);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_valid", rsp_valid, 0);
      check_eq("midrst_y", rsp_y, 0);
      check_eq("midrst_flags", {rsp_zero, rsp_ovf, rsp_carry, rsp_neg}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check_eq("midrst_no_rsp", rsp_valid, 0);
      end
      check_eq("midrst_ready", req_ready, 1);
      run_op(2'(SUB), 8'h05, 8'h09, 0, 1'b0);

`ifdef ALU8_SEQ_STICKY_OVF_EN
      check_eq("sticky_clear_start", sticky_ovf, 0);
      run_op(2'(ADD), 8'h7F, 8'h01, 0, 1'b0);
      check_eq("sticky_set1", sticky_ovf, 1);
      run_op(2'(ADD), 8'h40, 8'h40, 0, 1'b0);
      check_eq("sticky_set2", sticky_ovf, 1);
      run_op(2'(ADD), 8'h70, 8'h70, 0, 1'b1);
      check_eq("sticky_set_wins", sticky_ovf, 1);
      clr_sticky = 1'b1;
      @(posedge clk);
      #1;
      clr_sticky = 1'b0;
      check_eq("sticky_clr", sticky_ovf, 0);
`endif

      check_eq("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
